// File: rtl/pipe_hazard_if.sv
// Handshake bundle between the ID stage and the hazard/pipeline-control unit.
interface pipe_hazard_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_use1;
  logic                  id_use2;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_wb_en;
  logic                  id_mem_read;
  logic                  branch_taken;
  logic                  mem_busy;
  logic                  freeze_if;
  logic                  freeze_id;
  logic                  bubble_id;
  logic                  flush;
  logic [1:0]            fwd_sel_a;
  logic [1:0]            fwd_sel_b;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_use1, id_use2, id_dst, id_wb_en,
           id_mem_read, branch_taken, mem_busy,
    input  freeze_if, freeze_id, bubble_id, flush, fwd_sel_a, fwd_sel_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_use1, id_use2, id_dst, id_wb_en,
           id_mem_read, branch_taken, mem_busy,
    output freeze_if, freeze_id, bubble_id, flush, fwd_sel_a, fwd_sel_b, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit: scoreboard of in-flight writes, stall/flush controls.
// Optional PIPE_FWD_EN: stall only on load-use and drive registered forwarding selects.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W       = 4,
  parameter int STAGES           = 3,
  parameter int RF_WRITE_THROUGH = 1,
  parameter int CNT_W            = 16
) (
  input  logic          clk,
  input  logic          rst,
  pipe_hazard_if.slave  hz
);

  localparam int LAST = (RF_WRITE_THROUGH != 0) ? STAGES - 2 : STAGES - 1;

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] dst;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, wb_en: 1'b0, mem_read: 1'b0,
                                     dst: {REG_ADDR_W{1'b0}}};

  sb_entry_t        sb_r [STAGES];
  logic             flush_pend_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             raw_s;
  logic             hazard_s;
  logic             flush_now_s;
  logic             advance_s;
  logic             stall_s;
  logic             issue_s;
  logic             freeze_if_s;
  logic             freeze_id_s;
  logic             bubble_id_s;
  logic             flush_s;
  logic             unused_s;

  function automatic logic hit(input sb_entry_t e, input logic [REG_ADDR_W-1:0] src,
                               input logic use_f);
    return e.valid & e.wb_en & use_f & (e.dst == src);
  endfunction

  assign advance_s   = ~hz.mem_busy;
  assign flush_now_s = hz.branch_taken | flush_pend_r;
  assign stall_s     = ~hz.mem_busy & ~flush_now_s & hazard_s;
  assign issue_s     = hz.id_valid & ~stall_s & ~flush_now_s;

  // Any RAW dependence against the compared scoreboard entries.
  always_comb begin
    raw_s = 1'b0;
    for (int k = 0; k <= LAST; k++) begin
      raw_s = raw_s | hit(sb_r[k], hz.id_src1, hz.id_use1)
                    | hit(sb_r[k], hz.id_src2, hz.id_use2);
    end
  end

`ifdef PIPE_FWD_EN
  logic [1:0] fwd_a_r;
  logic [1:0] fwd_b_r;

  // Youngest producer wins: EXE/MEM register before MEM/WB register.
  function automatic logic [1:0] fwd_pick(input logic [REG_ADDR_W-1:0] src, input logic use_f);
    if (hit(sb_r[0], src, use_f)) begin
      return 2'd1;
    end else if ((LAST >= 1) && hit(sb_r[1], src, use_f)) begin
      return 2'd2;
    end else begin
      return 2'd0;
    end
  endfunction

  assign hazard_s = hz.id_valid & sb_r[0].mem_read &
                    (hit(sb_r[0], hz.id_src1, hz.id_use1) | hit(sb_r[0], hz.id_src2, hz.id_use2));

  // Forwarding selects for the instruction entering EXE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_r <= 2'd0;
      fwd_b_r <= 2'd0;
    end else if (advance_s) begin
      fwd_a_r <= issue_s ? fwd_pick(hz.id_src1, hz.id_use1) : 2'd0;
      fwd_b_r <= issue_s ? fwd_pick(hz.id_src2, hz.id_use2) : 2'd0;
    end
  end

  assign hz.fwd_sel_a = fwd_a_r;
  assign hz.fwd_sel_b = fwd_b_r;
`else
  assign hazard_s     = hz.id_valid & raw_s;
  assign hz.fwd_sel_a = 2'd0;
  assign hz.fwd_sel_b = 2'd0;
`endif

  // Scoreboard shift, pending-flush tracking and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sb_r[k] <= SB_EMPTY;
      end
      flush_pend_r <= 1'b0;
      stall_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (advance_s) begin
        for (int k = STAGES - 1; k > 0; k--) begin
          sb_r[k] <= sb_r[k-1];
        end
        sb_r[0] <= issue_s ? '{valid: 1'b1, wb_en: hz.id_wb_en, mem_read: hz.id_mem_read,
                               dst: hz.id_dst} : SB_EMPTY;
      end
      flush_pend_r <= hz.mem_busy ? (flush_pend_r | hz.branch_taken) : 1'b0;
      if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
    end
  end

  // Control priority: memory hold, then flush, then hazard stall.
  always_comb begin
    freeze_if_s = 1'b0;
    freeze_id_s = 1'b0;
    bubble_id_s = 1'b0;
    flush_s     = 1'b0;
    if (hz.mem_busy) begin
      freeze_if_s = 1'b1;
      freeze_id_s = 1'b1;
    end else if (flush_now_s) begin
      flush_s     = 1'b1;
      bubble_id_s = 1'b1;
    end else if (hazard_s) begin
      freeze_if_s = 1'b1;
      bubble_id_s = 1'b1;
    end else begin
      freeze_if_s = 1'b0;
    end
  end

  assign hz.freeze_if = freeze_if_s;
  assign hz.freeze_id = freeze_id_s;
  assign hz.bubble_id = bubble_id_s;
  assign hz.flush     = flush_s;
  assign hz.stall_cnt = stall_cnt_r;

  // The oldest entry and some load flags are not consumed in every configuration.
  assign unused_s = ^{sb_r[STAGES-1], raw_s, sb_r[0].mem_read};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (works with and without PIPE_FWD_EN).
module tb_pipe_hazard_ctrl;

  localparam int AW = 4;
  localparam int CW = 4;
`ifdef PIPE_FWD_EN
  localparam int LU_STALLS = 1;
`else
  localparam int LU_STALLS = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pipe_hazard_if #(.REG_ADDR_W(AW), .CNT_W(CW)) hz ();

  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .STAGES(3), .RF_WRITE_THROUGH(1), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  wire [3:0] ctrl = {hz.freeze_if, hz.freeze_id, hz.bubble_id, hz.flush};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic [AW-1:0] s1, input logic u1,
                          input logic [AW-1:0] s2, input logic u2, input logic [AW-1:0] d,
                          input logic wb, input logic mr);
    hz.id_valid    = v;
    hz.id_src1     = s1;
    hz.id_use1     = u1;
    hz.id_src2     = s2;
    hz.id_use2     = u2;
    hz.id_dst      = d;
    hz.id_wb_en    = wb;
    hz.id_mem_read = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  initial begin
    drive_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    hz.branch_taken = 1'b0;
    hz.mem_busy     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 32'(ctrl), 32'h0);
    check("rst_fwd", 32'({hz.fwd_sel_a, hz.fwd_sel_b}), 32'h0);
    check("rst_cnt", 32'(hz.stall_cnt), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset asserted while a load-use stall is active
    drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 1'b0);
    @(negedge clk);
    check("mid_stall", 32'(ctrl), 32'hA);
    #1 rst = 1'b1;
    #1;
    check("rst_async_ctrl", 32'(ctrl), 32'h0);
    check("rst_async_cnt", 32'(hz.stall_cnt), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_empty", 32'(ctrl), 32'h0);
    idle(3);

    // ADD r1 ; SUB r2,r1,r3
    drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    @(negedge clk);
    check("add_issue", 32'(ctrl), 32'h0);
    tick();
    drive_id(1'b1, 4'd1, 1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0);
    @(negedge clk);
`ifdef PIPE_FWD_EN
    check("sub_nostall", 32'(ctrl), 32'h0);
    tick();
    idle(0);
    check("sub_fwd_a", 32'(hz.fwd_sel_a), 32'd1);
    check("sub_fwd_b", 32'(hz.fwd_sel_b), 32'd0);
    check("sub_cnt", 32'(hz.stall_cnt), 32'd0);
`else
    check("sub_stall1", 32'(ctrl), 32'hA);
    tick();
    @(negedge clk);
    check("sub_stall2", 32'(ctrl), 32'hA);
    tick();
    @(negedge clk);
    check("sub_go", 32'(ctrl), 32'h0);
    check("sub_cnt", 32'(hz.stall_cnt), 32'd2);
    tick();
    idle(0);
    check("sub_fwd_a", 32'(hz.fwd_sel_a), 32'd0);
`endif
    idle(3);

    // LDR r4 ; ADD r5,r4,r4
    drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 4'd4, 1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b0);
    @(negedge clk);
    check("lu_stall1", 32'(ctrl), 32'hA);
    tick();
`ifdef PIPE_FWD_EN
    @(negedge clk);
    check("lu_go", 32'(ctrl), 32'h0);
    check("lu_cnt", 32'(hz.stall_cnt), 32'd1);
    tick();
    idle(0);
    check("lu_fwd_a", 32'(hz.fwd_sel_a), 32'd2);
    check("lu_fwd_b", 32'(hz.fwd_sel_b), 32'd2);
`else
    @(negedge clk);
    check("lu_stall2", 32'(ctrl), 32'hA);
    tick();
    @(negedge clk);
    check("lu_go", 32'(ctrl), 32'h0);
    check("lu_cnt", 32'(hz.stall_cnt), 32'd4);
    tick();
    idle(0);
    check("lu_fwd_a", 32'(hz.fwd_sel_a), 32'd0);
    check("lu_fwd_b", 32'(hz.fwd_sel_b), 32'd0);
`endif
    idle(3);

    // Matching address with use flags clear must not stall
    drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 4'd7, 1'b0, 4'd7, 1'b0, 4'd8, 1'b0, 1'b0);
    @(negedge clk);
    check("use_flag", 32'(ctrl), 32'h0);
    tick();
    idle(3);

    // Taken branch while ID holds a dependent load
    drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1);
    hz.branch_taken = 1'b1;
    @(negedge clk);
    check("br_flush", 32'(ctrl), 32'h3);
    tick();
    hz.branch_taken = 1'b0;
    check("br_fwd_a", 32'(hz.fwd_sel_a), 32'd0);
    drive_id(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd9, 1'b0, 1'b0);
    @(negedge clk);
    check("br_entry0_empty", 32'(ctrl), 32'h0);
    check("br_cnt", 32'(hz.stall_cnt), 32'(LU_STALLS + (LU_STALLS == 2 ? 2 : 0)));
    tick();
    idle(3);

    // Taken branch during a 3-cycle memory stall
    drive_id(1'b1, 4'd9, 1'b0, 4'd9, 1'b0, 4'd10, 1'b0, 1'b0);
    hz.branch_taken = 1'b1;
    hz.mem_busy     = 1'b1;
    @(negedge clk);
    check("mb_hold0", 32'(ctrl), 32'hC);
    tick();
    hz.branch_taken = 1'b0;
    @(negedge clk);
    check("mb_hold1", 32'(ctrl), 32'hC);
    tick();
    @(negedge clk);
    check("mb_hold2", 32'(ctrl), 32'hC);
    tick();
    hz.mem_busy = 1'b0;
    @(negedge clk);
    check("mb_flush", 32'(ctrl), 32'h3);
    tick();
    @(negedge clk);
    check("mb_clear", 32'(ctrl), 32'h0);
    idle(3);

    // Repeated r0 load-use pairs drive the counter into saturation
    for (int i = 0; i < 21; i++) begin
      drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1);
      tick();
      drive_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd11, 1'b0, 1'b0);
      if (i == 0) begin
        @(negedge clk);
        check("r0_stall", 32'(ctrl), 32'hA);
      end
      repeat (LU_STALLS + 1) tick();
    end
    idle(1);
    @(negedge clk);
    check("sat_cnt", 32'(hz.stall_cnt), 32'd15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and pipeline-control unit for the ARM 5-stage core.
- Drives the IF/ID freeze and flush inputs that the core currently ties to 0.
- Tracks in-flight register writes in a scoreboard shift register (EXE..WB) and produces stall, bubble and flush controls plus registered forwarding selects.
- Also handles multi-cycle memory stalls and taken-branch flushes.

Parameters:
- REG_ADDR_W, 4: register-address width; must match REG_FILE_DEPTH.
- STAGES, 3: tracked stages after ID. Entry 0 is EXE, entry 1 is MEM, entry 2 is WB.
- RF_WRITE_THROUGH, 1: when 1, the last entry (WB) is excluded from hazard/forward compares because the register file bypasses its own write.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_src1  in  REG_ADDR_W  Rn address.
- id_src2  in  REG_ADDR_W  Rm/Rd address.
- id_use1, id_use2  in  1 each  the source operand is actually read.
- id_dst  in  REG_ADDR_W  destination register.
- id_wb_en  in  1  ID instruction writes back.
- id_mem_read  in  1  ID instruction is a load.
- branch_taken  in  1  branch resolved taken in EXE.
- mem_busy  in  1  MEM stage needs more cycles; whole pipe holds.
- freeze_if  out  1  hold PC and IF_Reg.
- freeze_id  out  1  hold ID_Reg contents (mem_busy only).
- bubble_id  out  1  load a NOP into ID_Reg.
- flush  out  1  clear IF_Reg.
- fwd_sel_a, fwd_sel_b  out  2  operand source for the instruction now in EXE: 0 = register file, 1 = EXE/MEM register, 2 = MEM/WB register.
- stall_cnt  out  CNT_W  number of hazard-stall cycles.

Behaviour:
- Scoreboard:
  - STAGES entries, each {valid, wb_en, mem_read, dst}.
  - "advance" = !mem_busy.
  - On advance: entry[k] <= entry[k-1]. Entry 0 <= ID instruction, or a bubble (valid=0) when the cycle is a hazard stall, flush_now is set, or id_valid=0.
  - When advance=0, all entries hold.
- Match(s): entry k valid & wb_en & dst==s & use flag set. k ranges over 0..STAGES-1, or 0..STAGES-2 when RF_WRITE_THROUGH=1.
- hazard (combinational): id_valid & any Match on src1 or src2. With FWD_EN the rule is narrowed (see Optional Feature).
- flush_now = branch_taken | flush_pend.
- Control outputs, priority order:
  - mem_busy: freeze_if=1, freeze_id=1, bubble_id=0, flush=0.
  - Else flush_now: flush=1, bubble_id=1, freeze_if=0. Flush wins over hazard.
  - Else hazard: freeze_if=1, bubble_id=1.
  - Else all 0.
- flush_pend:
  - Set when branch_taken & mem_busy.
  - Cleared on the first advance cycle; flush is asserted in that cycle.
- fwd_sel (registered):
  - Updated on advance for the instruction entering EXE.
  - Value 1 if its source matches entry 0 (the producer moves to MEM). Else 2 if it matches entry 1. Else 0.
  - Youngest match wins.
  - Forced to 0 on bubble or when FWD_EN is undefined.
  - Held while mem_busy.
- stall_cnt:
  - Increments on each hazard-stall cycle (not mem_busy, not flush).
  - Saturates at all-ones.
- Register 0 is not special: ARM r0 is a real register.
- Reset (async): all entries invalid, flush_pend=0, fwd_sel=0, stall_cnt=0. Combinational outputs therefore read 0.
- Reset mid-stall discards the pending instruction state immediately.
- Latency:
  - Control outputs are same-cycle combinational from inputs and state.
  - fwd_sel is valid one cycle after the consumer leaves ID.

Optional Feature:
- Macro: PIPE_FWD_EN.
- Defined:
  - hazard is raised only for load-use: entry 0 valid & mem_read & wb_en & dst matches a used source.
  - All other RAW dependences are resolved through fwd_sel.
- Undefined:
  - Every Match stalls (non-forwarding pipeline).
  - fwd_sel_a and fwd_sel_b are constant 0.

Test Plan:
- Reset in the middle of a hazard stall (rst=1 while hazard active) -> all outputs 0 that same cycle; scoreboard empty afterwards.
- ADD r1 followed by SUB r2,r1,r3, forwarding off -> freeze_if=1 and bubble_id=1 for 2 cycles; stall_cnt=2. With PIPE_FWD_EN -> no stall; fwd_sel_a=1 when SUB enters EXE.
- LDR r4 followed by ADD r5,r4,r4 with PIPE_FWD_EN -> exactly 1 stall cycle; then fwd_sel_a=fwd_sel_b=2.
- branch_taken=1 while ID holds a dependent instruction -> flush=1 and bubble_id=1, freeze_if=0; next cycle entry 0 is invalid.
- branch_taken=1 with mem_busy=1 for 3 cycles -> freeze_if=1 and freeze_id=1, flush=0 throughout; flush=1 in the first cycle after mem_busy drops.
- Force 2^CNT_W+5 stall cycles (CNT_W=4 build) -> stall_cnt holds at 15.
